btn_conditioner: RTL and testbench

Conditions one raw push-button input for the DDR game before it reaches the VGA/game logic. Synchronises the asynchronous pin, debounces both edges, and produces a clean level, single-cycle press/release pulses, and a hold flag with auto-repeat pulses. One instance per button; its `btn_level`/`btn_press` outputs replace the raw `btn_up` wire feeding the game/VGA stage.

---
 rtl/btn_conditioner.sv | 132 +++++++++++++
 tb/tb_btn_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, dual-edge debounce FSM,
// single-cycle press/release pulses, and hold detection with auto-repeat.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold,
    output logic btn_repeat
);

    localparam int MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DB_DOWN = 2'd1,
        DOWN    = 2'd2,
        DB_UP   = 2'd3
    } state_t;

    state_t          state_reg;
    logic            s1_reg;
    logic            s2_reg;
    logic [CW-1:0]   dcnt_reg;
    logic [CW-1:0]   hcnt_reg;
    logic [CW-1:0]   rcnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            dcnt_reg    <= '0;
            hcnt_reg    <= '0;
            rcnt_reg    <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_hold    <= 1'b0;
            btn_repeat  <= 1'b0;
        end else begin
            s1_reg      <= btn_in;
            s2_reg      <= s1_reg;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;

            // Hold timing runs for the whole time the debounced level is high,
            // including release bounce; the release branch below overrides it.
            if (state_reg == DOWN || state_reg == DB_UP) begin
                if (!btn_hold) begin
                    if (hcnt_reg == HOLD_LAST) begin
                        btn_hold   <= 1'b1;
                        btn_repeat <= 1'b1;
                        rcnt_reg   <= '0;
                    end else begin
                        hcnt_reg <= hcnt_reg + CNT_ONE;
                    end
                end else if (rcnt_reg == REP_LAST) begin
                    btn_repeat <= 1'b1;
                    rcnt_reg   <= '0;
                end else begin
                    rcnt_reg <= rcnt_reg + CNT_ONE;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (s2_reg) begin
                        state_reg <= DB_DOWN;
                        dcnt_reg  <= CNT_ONE;
                    end
                end
                DB_DOWN: begin
                    if (!s2_reg) begin
                        state_reg <= IDLE;
                        dcnt_reg  <= '0;
                    end else if (dcnt_reg == DB_LAST) begin
                        state_reg <= DOWN;
                        dcnt_reg  <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                        hcnt_reg  <= '0;
                    end else begin
                        dcnt_reg <= dcnt_reg + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!s2_reg) begin
                        state_reg <= DB_UP;
                        dcnt_reg  <= CNT_ONE;
                    end
                end
                DB_UP: begin
                    if (s2_reg) begin
                        state_reg <= DOWN;
                        dcnt_reg  <= '0;
                    end else if (dcnt_reg == DB_LAST) begin
                        state_reg   <= IDLE;
                        dcnt_reg    <= '0;
                        hcnt_reg    <= '0;
                        rcnt_reg    <= '0;
                        btn_level   <= 1'b0;
                        btn_hold    <= 1'b0;
                        btn_repeat  <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        dcnt_reg <= dcnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    dcnt_reg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with explicit edge timing,
// then randomized bouncing input checked against a timestamp-based model.
module tb_btn_conditioner;

    localparam int DEB    = 4;
    localparam int HOLD   = 20;
    localparam int REPEAT = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level, btn_press, btn_release, btn_hold, btn_repeat;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: delay line for the synchroniser, a run length
    // of disagreeing samples, and the edge number of the last accepted press.
    int   edge_n       = 0;
    int   m_press_edge = 0;
    int   m_run        = 0;
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0;
    logic e_press = 1'b0, e_release = 1'b0, e_hold = 1'b0, e_repeat = 1'b0;

    wire [4:0] obs   = {btn_level, btn_press, btn_release, btn_hold, btn_repeat};
    wire [4:0] m_exp = {m_level, e_press, e_release, e_hold, e_repeat};

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REPEAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of inputs, advance the model, sample 1 ns later.
    task automatic tick(input logic b, input logic r);
        logic seen;
        int   k;
        btn_in = b;
        rst    = r;
        @(posedge clk);
        edge_n++;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
            e_press = 0; e_release = 0; e_hold = 0; e_repeat = 0;
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            e_press = 0; e_release = 0; e_repeat = 0;
            if (m_level) begin
                k        = edge_n - m_press_edge;
                e_hold   = (k >= HOLD);
                e_repeat = (k >= HOLD) && (((k - HOLD) % REPEAT) == 0);
            end else begin
                e_hold = 0;
            end
            if (seen != m_level) m_run++;
            else                 m_run = 0;
            if (m_run == DEB) begin
                m_run    = 0;
                e_hold   = 0;
                e_repeat = 0;
                if (!m_level) begin
                    m_level      = 1;
                    e_press      = 1;
                    m_press_edge = edge_n;
                end else begin
                    m_level   = 0;
                    e_release = 1;
                end
            end
        end
        #1;
    endtask

    task automatic go_idle();
        repeat (12) tick(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b0);
            vectors++;
            if (obs !== 5'b0) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %b want 00000", i, obs);
            end
        end
        go_idle();
    endtask

    task automatic test_clean_press();
        logic [4:0] exp;
        go_idle();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1);
            exp = {i >= 5, i == 5, 3'b000};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL clean_press edge %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_press();
        logic [5:0] pat;
        logic [4:0] exp;
        pat = 6'b011011;  // bit i = input before edge i: 1,1,0,1,1,0
        go_idle();
        for (int i = 0; i < 14; i++) begin
            tick((i < 6) ? pat[i] : 1'b1, 1'b1);
            exp = {i >= 11, i == 11, 3'b000};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL bounce_press edge %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_release();
        logic [4:0] exp;
        go_idle();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        for (int j = 0; j < 12; j++) begin
            tick(j == 3, 1'b1);
            exp = {j < 9, 1'b0, j == 9, 2'b00};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL bounce_release edge %0d: got %b want %b", j, obs, exp);
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [4:0] exp;
        logic       rep;
        go_idle();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        vectors++;
        if (btn_press !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_press_pulse: got %b want 1", btn_press);
        end
        for (int k = 1; k <= 70; k++) begin
            tick(k <= 60, 1'b1);
            rep = (k == 20 || k == 28 || k == 36 || k == 44 || k == 52 || k == 60);
            exp = {k < 66, 1'b0, k == 66, (k >= 20) && (k < 66), rep};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL hold_repeat P+%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_release_on_repeat();
        logic [4:0] exp;
        go_idle();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            tick(k <= 22, 1'b1);
            exp = {k < 28, 1'b0, k == 28, (k >= 20) && (k < 28), k == 20};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL release_on_repeat P+%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] exp;
        go_idle();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1, k != 25);
            exp = {(k < 25) || (k >= 31), k == 31, 1'b0,
                   (k >= 20) && (k < 25), k == 20};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid_hold P+%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        int   ticks = 0;
        int   len;
        logic lvl;
        go_idle();
        while (ticks < 1500) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 6);
            for (int n = 0; n < len; n++) begin
                tick(lvl, $urandom_range(0, 99) != 0);
                ticks++;
                vectors++;
                if (obs !== m_exp) begin
                    miscompares++;
                    $display("FAIL random edge %0d: got %b want %b", edge_n, obs, m_exp);
                end
            end
        end
    endtask

    initial begin
        btn_in = 1'b0;
        rst    = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_bounce_release();
        test_hold_repeat();
        test_release_on_repeat();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
